// File: rtl/switch_led_bank_if.sv
// rtl/switch_led_bank_if.sv - switch/mode inputs and LED/event/stable outputs of switch_led_bank
interface switch_led_bank_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] i_Switch;
  logic [1:0]        i_Mode;
  logic              i_Clear;
  logic [NUM_CH-1:0] o_Led;
  logic [NUM_CH-1:0] o_Event;
  logic [NUM_CH-1:0] o_Stable;

  modport master (
    output i_Switch, i_Mode, i_Clear,
    input  o_Led, o_Event, o_Stable
  );

  modport slave (
    input  i_Switch, i_Mode, i_Clear,
    output o_Led, o_Event, o_Stable
  );
endinterface

// File: rtl/switch_led_bank.sv
// rtl/switch_led_bank.sv - per-channel switch synchroniser, debouncer and mode-driven LED control
module switch_led_bank #(
  parameter int NUM_CH          = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input logic              i_Clk,
  input logic              i_Rst_L,
  switch_led_bank_if.slave sw
);
  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_RELEASE = 2'd0,
    MODE_PRESS   = 2'd1,
    MODE_FOLLOW  = 2'd2,
    MODE_OFF     = 2'd3
  } mode_e;

  logic [SYNC_STAGES-1:0] sync_q [NUM_CH];
  logic [CNT_W-1:0]       cnt_q  [NUM_CH];
  logic [NUM_CH-1:0]      stable_q;
  logic [NUM_CH-1:0]      led_q;
  logic [NUM_CH-1:0]      event_q;

  logic [NUM_CH-1:0] s;
  logic [NUM_CH-1:0] update;
  logic [NUM_CH-1:0] stable_d;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] fall;

  // update fires on the last cycle of an unbroken run of s differing from stable
  always_comb begin
    s      = '0;
    update = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      s[n]      = sync_q[n][SYNC_STAGES-1];
      update[n] = (s[n] != stable_q[n]) && (cnt_q[n] == CNT_LAST);
    end
    stable_d = (stable_q & ~update) | (s & update);
    rise     = update & s;
    fall     = update & ~s;
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      for (int n = 0; n < NUM_CH; n++) begin
        sync_q[n] <= '0;
        cnt_q[n]  <= '0;
      end
      stable_q <= '0;
      led_q    <= '0;
      event_q  <= '0;
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        sync_q[n] <= {sync_q[n][SYNC_STAGES-2:0], sw.i_Switch[n]};
        if ((s[n] == stable_q[n]) || update[n]) begin
          cnt_q[n] <= '0;
        end else begin
          cnt_q[n] <= cnt_q[n] + CNT_W'(1);
        end
      end
      stable_q <= stable_d;
      // clear beats a same-cycle toggle but never masks the event pulse
      case (mode_e'(sw.i_Mode))
        MODE_RELEASE: begin
          event_q <= fall;
          led_q   <= sw.i_Clear ? '0 : (led_q ^ fall);
        end
        MODE_PRESS: begin
          event_q <= rise;
          led_q   <= sw.i_Clear ? '0 : (led_q ^ rise);
        end
        MODE_FOLLOW: begin
          event_q <= rise | fall;
          led_q   <= stable_d;
        end
        default: begin
          event_q <= '0;
          led_q   <= '0;
        end
      endcase
    end
  end

  assign sw.o_Led    = led_q;
  assign sw.o_Event  = event_q;
  assign sw.o_Stable = stable_q;
endmodule
